i2c_target_responder: RTL and testbench

- Synthesisable, parametrised I2C target (slave) for the I2C-APB master.
- Replaces hand-timed SDA pulls on the bus with a protocol-correct responder: address match, ACK/NACK, byte-addressed memory, read-back.
- Sits on the open-drain sda/scl pair alongside the master's top_level and runs on core_clk, oversampling SCL/SDA.
- Also usable as an on-chip loopback target.

---
 rtl/i2c_target_responder_if.sv | 24 ++
 rtl/i2c_target_responder.sv | 228 ++++++++++++++++++++++
 tb/tb_i2c_target_responder.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_target_responder_if.sv
// rtl/i2c_target_responder_if.sv - bus pins and write-event outputs of the I2C target responder.
interface i2c_target_responder_if #(
  parameter int DATA_W = 8,
  parameter int PTR_W  = 4
);
  logic              scl_in;
  logic              sda_in;
  logic              sda_oe;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic [PTR_W-1:0]  rx_ptr;
  logic              busy;
  logic              nack_seen;

  modport slave (
    input  scl_in, sda_in,
    output sda_oe, rx_valid, rx_data, rx_ptr, busy, nack_seen
  );

  modport master (
    output scl_in, sda_in,
    input  sda_oe, rx_valid, rx_data, rx_ptr, busy, nack_seen
  );
endinterface

// File: rtl/i2c_target_responder.sv
// rtl/i2c_target_responder.sv - oversampling I2C target with address match, ACK/NACK and byte memory.
module i2c_target_responder #(
  parameter logic [6:0] TARGET_ADDR = 7'h10,
  parameter int DATA_W      = 8,
  parameter int MEM_DEPTH   = 16,
  parameter int PTR_MODE    = 1,
  parameter int NACK_AFTER  = 0,
  parameter int SYNC_STAGES = 2
) (
  input logic core_clk,
  input logic PRESET,
  i2c_target_responder_if.slave bus
);
  localparam int PTR_W = $clog2(MEM_DEPTH);
  localparam int SH_W  = (DATA_W > 8) ? DATA_W : 8;
  localparam int CNT_W = $clog2(SH_W + 1);
  localparam logic [15:0] NACK_LIM = 16'(NACK_AFTER);

  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE} state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_q, sda_q;
  logic scl_rise, scl_fall, start, stop;

  always_ff @(posedge core_clk or posedge PRESET) begin
    if (PRESET) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_in};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_q;
  assign scl_fall = ~scl_s & scl_q;
  assign start    = scl_s & scl_q & sda_q & ~sda_s;
  assign stop     = scl_s & scl_q & ~sda_q & sda_s;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [SH_W-2:0]   rx_sh, rx_sh_n;
  logic [DATA_W-1:0] tx_sh, tx_sh_n;
  logic [PTR_W-1:0]  ptr, ptr_n;
  logic              first, first_n, ack_ph, ack_ph_n, rw, rw_n;
  logic [15:0]       wr_cnt, wr_cnt_n;
  logic              sda_oe_q, sda_oe_n, busy_q, busy_n, nack_q, nack_n;
  logic              rx_valid_q, rx_valid_n;
  logic [DATA_W-1:0] rx_data_q, rx_data_n;
  logic [PTR_W-1:0]  rx_ptr_q, rx_ptr_n;
  logic              mem_we;
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [DATA_W-1:0] rd_word, rx_byte;
  logic [7:0]        addr_byte;

  assign rd_word   = mem[ptr];
  assign rx_byte   = {rx_sh[DATA_W-2:0], sda_s};
  assign addr_byte = {rx_sh[6:0], sda_s};

  always_ff @(posedge core_clk or posedge PRESET) begin
    if (PRESET) begin
      state      <= IDLE;
      cnt        <= '0;
      rx_sh      <= '0;
      tx_sh      <= '0;
      ptr        <= '0;
      first      <= 1'b0;
      ack_ph     <= 1'b0;
      rw         <= 1'b0;
      wr_cnt     <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      nack_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_ptr_q   <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      rx_sh      <= rx_sh_n;
      tx_sh      <= tx_sh_n;
      ptr        <= ptr_n;
      first      <= first_n;
      ack_ph     <= ack_ph_n;
      rw         <= rw_n;
      wr_cnt     <= wr_cnt_n;
      sda_oe_q   <= sda_oe_n;
      busy_q     <= busy_n;
      nack_q     <= nack_n;
      rx_valid_q <= rx_valid_n;
      rx_data_q  <= rx_data_n;
      rx_ptr_q   <= rx_ptr_n;
      if (mem_we) mem[ptr] <= rx_byte;
    end
  end

  // START/STOP override every state; otherwise bus activity only advances on SCL edges.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    rx_sh_n    = rx_sh;
    tx_sh_n    = tx_sh;
    ptr_n      = ptr;
    first_n    = first;
    ack_ph_n   = ack_ph;
    rw_n       = rw;
    wr_cnt_n   = wr_cnt;
    sda_oe_n   = sda_oe_q;
    busy_n     = busy_q;
    nack_n     = nack_q;
    rx_valid_n = 1'b0;
    rx_data_n  = rx_data_q;
    rx_ptr_n   = rx_ptr_q;
    mem_we     = 1'b0;
    if (start) begin
      state_n  = ADDR;
      cnt_n    = '0;
      nack_n   = 1'b0;
      sda_oe_n = 1'b0;
      wr_cnt_n = '0;
      first_n  = 1'b0;
      ack_ph_n = 1'b0;
      if (PTR_MODE == 0) ptr_n = '0;
    end else if (stop) begin
      state_n  = IDLE;
      busy_n   = 1'b0;
      sda_oe_n = 1'b0;
    end else begin
      case (state)
        ADDR: if (scl_rise) begin
          rx_sh_n = {rx_sh[SH_W-3:0], sda_s};
          cnt_n   = cnt + 1'b1;
          if (cnt == CNT_W'(7)) begin
            if (addr_byte[7:1] == TARGET_ADDR) begin
              state_n  = ADDR_ACK;
              busy_n   = 1'b1;
              rw_n     = addr_byte[0];
              ack_ph_n = 1'b0;
            end else begin
              state_n = IGNORE;
              busy_n  = 1'b0;
            end
          end
        end
        ADDR_ACK, WR_ACK: if (scl_fall) begin
          if (!ack_ph) begin
            sda_oe_n = 1'b1;
            ack_ph_n = 1'b1;
          end else begin
            ack_ph_n = 1'b0;
            cnt_n    = '0;
            sda_oe_n = 1'b0;
            if (state == ADDR_ACK && rw) begin
              // First read bit goes out on the same edge that ends the address ACK.
              state_n  = RD_DATA;
              sda_oe_n = ~rd_word[DATA_W-1];
              tx_sh_n  = {rd_word[DATA_W-2:0], 1'b0};
              cnt_n    = CNT_W'(1);
            end else begin
              state_n = WR_DATA;
              if (state == ADDR_ACK) first_n = (PTR_MODE != 0);
            end
          end
        end
        WR_DATA: if (scl_rise) begin
          rx_sh_n = {rx_sh[SH_W-3:0], sda_s};
          cnt_n   = cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W - 1)) begin
            if (first) begin
              ptr_n    = rx_byte[PTR_W-1:0];
              first_n  = 1'b0;
              state_n  = WR_ACK;
              ack_ph_n = 1'b0;
            end else if (NACK_AFTER != 0 && wr_cnt >= NACK_LIM) begin
              state_n = IGNORE;
            end else begin
              mem_we     = 1'b1;
              rx_valid_n = 1'b1;
              rx_data_n  = rx_byte;
              rx_ptr_n   = ptr;
              ptr_n      = ptr + 1'b1;
              if (wr_cnt != '1) wr_cnt_n = wr_cnt + 16'd1;
              state_n    = WR_ACK;
              ack_ph_n   = 1'b0;
            end
          end
        end
        RD_DATA: if (scl_fall) begin
          if (cnt == CNT_W'(DATA_W)) begin
            sda_oe_n = 1'b0;
            state_n  = RD_ACK;
            ptr_n    = ptr + 1'b1;
          end else begin
            sda_oe_n = ~tx_sh[DATA_W-1];
            tx_sh_n  = {tx_sh[DATA_W-2:0], 1'b0};
            cnt_n    = cnt + 1'b1;
          end
        end
        RD_ACK: if (scl_rise) begin
          if (!sda_s) begin
            state_n = RD_DATA;
            tx_sh_n = rd_word;
            cnt_n   = '0;
          end else begin
            nack_n  = 1'b1;
            state_n = IGNORE;
          end
        end
        IGNORE:  sda_oe_n = 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.sda_oe    = sda_oe_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_ptr    = rx_ptr_q;
  assign bus.busy      = busy_q;
  assign bus.nack_seen = nack_q;
endmodule

// File: tb/tb_i2c_target_responder.sv
// tb/tb_i2c_target_responder.sv - directed I2C master bench for i2c_target_responder.
module tb_i2c_target_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic sel = 1'b0;
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  i2c_target_responder_if #(.DATA_W(8), .PTR_W(4)) ifa ();
  i2c_target_responder_if #(.DATA_W(8), .PTR_W(4)) ifb ();

  assign ifa.scl_in = sel ? 1'b1 : scl_m;
  assign ifa.sda_in = (sel ? 1'b1 : sda_m) & ~ifa.sda_oe;
  assign ifb.scl_in = sel ? scl_m : 1'b1;
  assign ifb.sda_in = (sel ? sda_m : 1'b1) & ~ifb.sda_oe;
  wire line = sel ? ifb.sda_in : ifa.sda_in;

  i2c_target_responder #(.TARGET_ADDR(7'h10), .DATA_W(8), .MEM_DEPTH(16), .PTR_MODE(1),
                         .NACK_AFTER(2), .SYNC_STAGES(2))
    dut_a (.core_clk(clk), .PRESET(rst), .bus(ifa.slave));

  i2c_target_responder #(.TARGET_ADDR(7'h10), .DATA_W(8), .MEM_DEPTH(16), .PTR_MODE(0),
                         .NACK_AFTER(0), .SYNC_STAGES(2))
    dut_b (.core_clk(clk), .PRESET(rst), .bus(ifb.slave));

  logic [11:0] q_a[$];
  logic [11:0] q_b[$];
  bit oe_a, oe_b;

  always @(posedge clk) begin
    if (ifa.rx_valid) q_a.push_back({ifa.rx_ptr, ifa.rx_data});
    if (ifb.rx_valid) q_b.push_back({ifb.rx_ptr, ifb.rx_data});
    if (ifa.sda_oe) oe_a = 1'b1;
    if (ifb.sda_oe) oe_b = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic half();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic bit_io(input logic v, output logic s);
    sda_m = v;
    half();
    scl_m = 1'b1;
    half();
    s = line;
    scl_m = 1'b0;
    half();
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; half();
    scl_m = 1'b1; half();
    sda_m = 1'b0; half();
    scl_m = 1'b0; half();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; half();
    scl_m = 1'b1; half();
    sda_m = 1'b1; half();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) bit_io(b[i], s);
    bit_io(1'b1, s);
    acked = ~s;
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic m_ack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, s);
      b[i] = s;
    end
    bit_io(~m_ack, s);
  endtask

  initial begin
    logic ack, s;
    logic [7:0] rb;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    half();
    check("reset_sda_oe", ifa.sda_oe, 0);
    check("reset_rx_valid", ifa.rx_valid, 0);
    check("reset_rx_data", ifa.rx_data, 0);
    check("reset_rx_ptr", ifa.rx_ptr, 0);
    check("reset_busy", ifa.busy, 0);
    check("reset_nack_seen", ifa.nack_seen, 0);
    check("reset_b_sda_oe", ifb.sda_oe, 0);

    // Write 0x03 pointer then 0xA5, 0x5A
    q_a.delete();
    i2c_start();
    send_byte(8'h20, ack); check("wr_addr_ack", ack, 1);
    check("wr_busy_after_match", ifa.busy, 1);
    send_byte(8'h03, ack); check("wr_ptr_ack", ack, 1);
    send_byte(8'hA5, ack); check("wr_byte1_ack", ack, 1);
    send_byte(8'h5A, ack); check("wr_byte2_ack", ack, 1);
    i2c_stop();
    check("wr_busy_after_stop", ifa.busy, 0);
    check("wr_rx_count", q_a.size(), 2);
    if (q_a.size() == 2) begin
      check("wr_rx0", q_a[0], 12'h3A5);
      check("wr_rx1", q_a[1], 12'h45A);
    end

    // Address mismatch
    q_a.delete();
    oe_a = 1'b0;
    i2c_start();
    send_byte(8'h22, ack); check("mm_addr_nack", ack, 0);
    check("mm_busy", ifa.busy, 0);
    send_byte(8'h11, ack); check("mm_data_nack", ack, 0);
    i2c_stop();
    check("mm_oe_never", oe_a, 0);
    check("mm_rx_count", q_a.size(), 0);

    // Read back through a repeated START
    i2c_start();
    send_byte(8'h20, ack); check("rd_addr_w_ack", ack, 1);
    send_byte(8'h03, ack); check("rd_ptr_ack", ack, 1);
    i2c_start();
    send_byte(8'h21, ack); check("rd_addr_r_ack", ack, 1);
    recv_byte(rb, 1'b1); check("rd_byte0", rb, 8'hA5);
    check("rd_nack_seen_after_ack", ifa.nack_seen, 0);
    recv_byte(rb, 1'b0); check("rd_byte1", rb, 8'h5A);
    check("rd_nack_seen", ifa.nack_seen, 1);
    i2c_stop();
    check("rd_busy_after_stop", ifa.busy, 0);

    // Pointer wrap and NACK after two data bytes
    q_a.delete();
    i2c_start();
    check("wrap_nack_seen_cleared", ifa.nack_seen, 0);
    send_byte(8'h20, ack); check("wrap_addr_ack", ack, 1);
    send_byte(8'h0F, ack); check("wrap_ptr_ack", ack, 1);
    send_byte(8'h01, ack); check("wrap_b1_ack", ack, 1);
    send_byte(8'h02, ack); check("wrap_b2_ack", ack, 1);
    send_byte(8'h03, ack); check("wrap_b3_nack", ack, 0);
    i2c_stop();
    check("wrap_rx_count", q_a.size(), 2);
    if (q_a.size() == 2) begin
      check("wrap_rx0", q_a[0], 12'hF01);
      check("wrap_rx1", q_a[1], 12'h002);
    end

    // Read 15, 0, 1 to confirm wrap and that the NACKed byte was dropped
    i2c_start();
    send_byte(8'h20, ack);
    send_byte(8'h0F, ack);
    i2c_start();
    send_byte(8'h21, ack); check("wrap_rd_addr_ack", ack, 1);
    recv_byte(rb, 1'b1); check("wrap_rd_15", rb, 8'h01);
    recv_byte(rb, 1'b1); check("wrap_rd_0", rb, 8'h02);
    recv_byte(rb, 1'b0); check("wrap_rd_1", rb, 8'h00);
    i2c_stop();

    // Reset during the 4th bit of a data byte
    i2c_start();
    send_byte(8'h20, ack);
    send_byte(8'h03, ack);
    check("rst_busy_before", ifa.busy, 1);
    bit_io(1'b1, s);
    bit_io(1'b0, s);
    bit_io(1'b1, s);
    sda_m = 1'b0;
    half();
    scl_m = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_sda_oe_now", ifa.sda_oe, 0);
    check("rst_busy_now", ifa.busy, 0);
    sda_m = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    half();
    i2c_start();
    send_byte(8'h20, ack); check("rst_rematch_ack", ack, 1);
    send_byte(8'h03, ack);
    i2c_start();
    send_byte(8'h21, ack); check("rst_rd_addr_ack", ack, 1);
    recv_byte(rb, 1'b0); check("rst_mem_cleared", rb, 8'h00);
    i2c_stop();

    // PTR_MODE=0 target: first write byte is data at pointer 0
    sel = 1'b1;
    half();
    q_b.delete();
    oe_b = 1'b0;
    i2c_start();
    send_byte(8'h20, ack); check("pm0_addr_ack", ack, 1);
    send_byte(8'h77, ack); check("pm0_data_ack", ack, 1);
    i2c_stop();
    check("pm0_rx_count", q_b.size(), 1);
    if (q_b.size() == 1) check("pm0_rx0", q_b[0], 12'h077);
    check("pm0_oe_used", oe_b, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
